// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the data-memory responder
// Purpose: window constants, write-buffer sizing, port-state enum and the
//          write-buffer entry struct shared by dmem_responder and its RAM.
package dmem_pkg;
  localparam logic [31:0] WIN_BASE  = 32'h0000_0780;
  localparam logic [31:0] WIN_LIMIT = 32'h0000_0B7F;
  localparam int ADDR_BITS = 10;
  localparam int DEPTH     = 2 ** ADDR_BITS;
  localparam int WB_DEPTH  = 4;
  localparam int PTR_BITS  = $clog2(WB_DEPTH);
  localparam int CNT_BITS  = PTR_BITS + 1;

  typedef logic [ADDR_BITS-1:0] addr_t;
  typedef logic [PTR_BITS-1:0]  ptr_t;
  typedef logic [CNT_BITS-1:0]  cnt_t;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_READ,
    PORT_DRAIN
  } port_state_t;

  typedef struct packed {
    logic        valid;
    addr_t       addr;
    logic [31:0] data;
  } wb_entry_t;
endpackage

// File: rtl/dmem_sram.sv
// rtl/dmem_sram.sv - single-port synchronous RAM behind the write buffer
// Purpose: DEPTH x 32 RAM, one access per cycle, 1-cycle registered read.
// Ports:   clk; en (access this cycle); we (1 = write, 0 = read);
//          addr (word address); wdata (write data); rdata (read data,
//          holds until the next read).
module dmem_sram #(
  parameter int ADDR_BITS = 10,
  parameter int DEPTH     = 2 ** ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory window responder with posted write buffer
// Purpose: accepts decoded read/write requests, posts writes into a small
//          in-order buffer that drains to RAM when the port is free, and
//          answers reads one cycle later with buffer forwarding.
// Ports:   clk, rst (async, active low); CS/iWE/iAddress/dataIn request;
//          ready (request accepted this cycle if CS); dataOut/readValid read
//          response; idle (buffer empty); wbCount (buffer occupancy).
module dmem_responder
  import dmem_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                CS,
  input  logic                iWE,
  input  logic [31:0]         iAddress,
  input  logic [31:0]         dataIn,
  output logic                ready,
  output logic [31:0]         dataOut,
  output logic                readValid,
  output logic                idle,
  output logic [CNT_BITS-1:0] wbCount
);
  wb_entry_t   wb [WB_DEPTH];
  ptr_t        head, tail, idx;
  cnt_t        count;
  port_state_t state_q, state_d;
  addr_t       word, ram_addr;
  logic [31:0] dout_q, ram_rdata, fwd_data;
  logic        accept, wr_acc, rd_acc, hit, drain;
  logic        unused_addr_bits;

  assign word             = iAddress[ADDR_BITS-1:0];
  assign unused_addr_bits = ^iAddress[31:ADDR_BITS];

  assign ready   = (count != cnt_t'(WB_DEPTH));
  assign idle    = (count == '0);
  assign wbCount = count;
  assign accept  = CS && ready;
  assign wr_acc  = accept && iWE;
  assign rd_acc  = accept && !iWE;

  // Walk from oldest to youngest so the last match (youngest) wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + ptr_t'(k);
      if ((cnt_t'(k) < count) && wb[idx].valid && (wb[idx].addr == word)) begin
        hit      = 1'b1;
        fwd_data = wb[idx].data;
      end
    end
  end

  // RAM port owner: a missed read beats the drain; a forwarded read leaves
  // the port free so draining continues.
  always_comb begin
    state_d = PORT_IDLE;
    if (rd_acc && !hit)    state_d = PORT_READ;
    else if (count != '0)  state_d = PORT_DRAIN;
  end

  assign drain    = (state_d == PORT_DRAIN);
  assign ram_addr = drain ? wb[head].addr : word;

  dmem_sram #(
    .ADDR_BITS(ADDR_BITS),
    .DEPTH    (DEPTH)
  ) u_sram (
    .clk  (clk),
    .en   (state_d != PORT_IDLE),
    .we   (drain),
    .addr (ram_addr),
    .wdata(wb[head].data),
    .rdata(ram_rdata)
  );

  // After a missed read the RAM output is the response; it is captured into
  // dout_q so dataOut keeps holding it once the RAM is used for draining.
  assign dataOut = (state_q == PORT_READ) ? ram_rdata : dout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      state_q   <= PORT_IDLE;
      readValid <= 1'b0;
      dout_q    <= '0;
      for (int i = 0; i < WB_DEPTH; i++) wb[i] <= '0;
    end else begin
      state_q   <= state_d;
      readValid <= rd_acc;
      if (state_q == PORT_READ) dout_q <= ram_rdata;
      if (rd_acc && hit)        dout_q <= fwd_data;
      if (wr_acc) begin
        wb[tail] <= '{valid: 1'b1, addr: word, data: dataIn};
        tail     <= tail + ptr_t'(1);
      end
      if (drain) begin
        wb[head].valid <= 1'b0;
        head           <= head + ptr_t'(1);
      end
      count <= count + cnt_t'(wr_acc) - cnt_t'(drain);
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0, rst = 1'b0, CS = 1'b0, iWE = 1'b0;
  logic [31:0] iAddress = '0, dataIn = '0;
  logic        ready, readValid, idle;
  logic [31:0] dataOut;
  logic [2:0]  wbCount;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst), .CS(CS), .iWE(iWE), .iAddress(iAddress),
    .dataIn(dataIn), .ready(ready), .dataOut(dataOut),
    .readValid(readValid), .idle(idle), .wbCount(wbCount)
  );

  int checks = 0, errors = 0;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } wr_t;

  // Reference: pending posted writes in order, and what has reached RAM.
  wr_t         q[$];
  logic [31:0] ram_model [DEPTH];
  bit          ram_known [DEPTH];
  logic [31:0] exp_dout = '0;
  bit          dout_known = 1'b1;
  bit          exp_rv = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at the low phase, check status before the edge,
  // advance the model at the edge, check the response at the next low phase.
  task automatic cycle(input bit cs, input bit we, input logic [31:0] a,
                       input logic [31:0] d, input bit rst_mid = 1'b0);
    bit          acc, miss, hit;
    logic [9:0]  wa;
    logic [31:0] v;
    CS = cs; iWE = we; iAddress = a; dataIn = d;
    #1;
    check("ready", ready, (q.size() != WB_DEPTH));
    check("wbCount", wbCount, q.size());
    check("idle", idle, (q.size() == 0));
    @(posedge clk);
    wa     = a[9:0];
    acc    = cs && rst && (q.size() != WB_DEPTH);
    miss   = 1'b0;
    hit    = 1'b0;
    v      = '0;
    exp_rv = acc && !we;
    if (exp_rv) begin
      foreach (q[i]) if (q[i].a == wa) begin hit = 1'b1; v = q[i].d; end
      if (hit) begin
        exp_dout = v; dout_known = 1'b1;
      end else begin
        miss = 1'b1; exp_dout = ram_model[wa]; dout_known = ram_known[wa];
      end
    end
    if (rst && q.size() > 0 && !miss) begin
      ram_model[q[0].a] = q[0].d;
      ram_known[q[0].a] = 1'b1;
      void'(q.pop_front());
    end
    if (acc && we) q.push_back('{wa, d});
    if (rst_mid) begin
      #2 rst = 1'b0;
      q.delete();
      exp_rv = 1'b0; exp_dout = '0; dout_known = 1'b1;
      #1;
      check("rst_wbCount", wbCount, 0);
      check("rst_idle", idle, 1);
    end
    @(negedge clk);
    check("readValid", readValid, exp_rv);
    if (dout_known) check("dataOut", dataOut, exp_dout);
  endtask

  task automatic settle();
    int guard = 0;
    while ((q.size() > 0) && (guard < 20)) begin
      cycle(1'b0, 1'b0, '0, '0);
      guard++;
    end
    cycle(1'b0, 1'b0, '0, '0);
    check("settle_idle", idle, 1);
  endtask

  initial begin
    foreach (ram_known[i]) ram_known[i] = 1'b0;

    // Reset with CS low
    repeat (2) begin
      @(negedge clk);
      check("reset_readValid", readValid, 0);
      check("reset_ready", ready, 1);
      check("reset_idle", idle, 1);
      check("reset_wbCount", wbCount, 0);
      check("reset_dataOut", dataOut, 0);
    end
    rst = 1'b1;

    // Write then drain, read back
    cycle(1'b1, 1'b1, 32'h005, 32'hDEADBEEF);
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 32'h005, '0);
    check("rd005", dataOut, 32'hDEADBEEF);
    cycle(1'b0, 1'b0, '0, '0);

    // Back-to-back writes then a read of one of them
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 32'h010 + i, 32'hA0 + i);
    cycle(1'b1, 1'b0, 32'h012, '0);
    check("rd012", dataOut, 32'hA2);
    cycle(1'b0, 1'b0, '0, '0);
    settle();

    // Same address twice, youngest wins
    cycle(1'b1, 1'b1, 32'h020, 32'h1);
    cycle(1'b1, 1'b1, 32'h020, 32'h2);
    cycle(1'b1, 1'b0, 32'h020, '0);
    check("rd020_fwd", dataOut, 32'h2);
    settle();
    cycle(1'b1, 1'b0, 32'h020, '0);
    check("rd020_ram", dataOut, 32'h2);

    // Writes interleaved with reads; upper address bits ignored
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 32'hFFFF_F040 + i, 32'hC0 + i);
      if (i < 4) cycle(1'b1, 1'b0, 32'h010 + i, '0);
    end
    settle();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, 32'h040 + i, '0);
      check("rd04x", dataOut, 32'hC0 + i);
    end

    // Write immediately followed by read of the same address
    cycle(1'b1, 1'b1, 32'h050, 32'h5555_AAAA);
    cycle(1'b1, 1'b0, 32'h050, '0);
    check("rd050", dataOut, 32'h5555_AAAA);
    settle();

    // Reset mid-operation discards buffered writes and the read in flight
    cycle(1'b1, 1'b1, 32'h032, 32'h1111_1111);
    settle();
    cycle(1'b1, 1'b1, 32'h030, 32'h3030_3030);
    cycle(1'b1, 1'b1, 32'h031, 32'h3131_3131);
    cycle(1'b1, 1'b1, 32'h032, 32'h2222_2222);
    cycle(1'b1, 1'b0, 32'h031, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 32'h032, '0);
    check("rd032_after_rst", dataOut, 32'h1111_1111);
    cycle(1'b1, 1'b0, 32'h031, '0);
    cycle(1'b0, 1'b0, '0, '0);

    // Randomized traffic over a small address set
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 32'h3F0 + i, $urandom);
    settle();
    for (int n = 0; n < 400; n++)
      cycle(($urandom_range(3) != 0), $urandom_range(1), 32'h3F0 + $urandom_range(15), $urandom);
    settle();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 32'h3F0 + i, '0);
    cycle(1'b0, 1'b0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
